// File: rtl/mydiv.sv
// mydiv: sequential restoring divider, one quotient bit per clock; define MYDIV_SIGNED_EN for two's-complement operands
module mydiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] d;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH:0]   npr;
  logic [WIDTH-1:0] ndq;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  // dq holds the not-yet-consumed dividend bits in its top and the growing quotient in its bottom
  assign trial = {pr, dq[WIDTH-1]} - {2'b0, d};
  assign ge    = !trial[WIDTH+1];
  assign npr   = ge ? trial[WIDTH:0] : {pr[WIDTH-1:0], dq[WIDTH-1]};
  assign ndq   = {dq[WIDTH-2:0], ge};
`ifdef MYDIV_SIGNED_EN
  logic q_neg;
  logic r_neg;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = q_neg ? -ndq : ndq;
  assign r_fin = r_neg ? -npr[WIDTH-1:0] : npr[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q_neg, r_neg} <= '0;
    else if (state == IDLE && start) {q_neg, r_neg} <= {dividend[WIDTH-1] ^ divisor[WIDTH-1], dividend[WIDTH-1]};
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = ndq;
  assign r_fin = npr[WIDTH-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dq          <= '0;
      d           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          cnt         <= CW'(WIDTH - 1);
          pr          <= '0;
          dq          <= a_mag;
          d           <= b_mag;
          div_by_zero <= divisor == '0;
          if (divisor == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= dividend;
          end else state <= CALC;
        end
        CALC: begin
          pr  <= npr;
          dq  <= ndq;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mydiv.sv
// tb_mydiv: directed divide vectors checked against a cycle-timeline reference model plus literal results
module tb_mydiv;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  int checks = 0;
  int failures = 0;

  mydiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = b == '0;
    if (z) begin
      q = '1;
      r = a;
    end
`ifdef MYDIV_SIGNED_EN
    else begin
      q = W'(int'($signed(a)) / int'($signed(b)));
      r = W'(int'($signed(a)) % int'($signed(b)));
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Model: k counts cycles since accept (0 = idle); the done cycle is k == lat
  int           k = 0;
  int           lat = 0;
  logic [W-1:0] pq = '0, pr_ = '0, mq = '0, mr = '0;
  logic         pz = 1'b0, mz = 1'b0;

  always @(negedge rst_n) begin
    k = 0;
    mq = '0;
    mr = '0;
    mz = 1'b0;
  end

  always @(posedge clk) if (rst_n) begin
    if (k == 0) begin
      if (start) begin
        k = 1;
        lat = (divisor == '0) ? 1 : W + 1;
        mz = 1'b0;
        model_div(dividend, divisor, pq, pr_, pz);
      end
    end else k = (k == lat) ? 0 : k + 1;
    if (k != 0 && k == lat) begin
      mq = pq;
      mr = pr_;
      mz = pz;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("busy", busy, k != 0);
    chk("done", done, k != 0 && k == lat);
    chk("quotient", quotient, mq);
    chk("remainder", remainder, mr);
    chk("div_by_zero", div_by_zero, mz);
  end

  task automatic wait_done(output int l, output int nb);
    l = 0;
    nb = 0;
    for (int i = 0; i < 30 && l == 0; i++) begin
      nb += int'(busy);
      if (done) l = i + 1;
      else @(negedge clk);
    end
  endtask

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, output int l, output int nb);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(l, nb);
  endtask

  int l, nb, nd;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    go(100, 7, l, nb);
    chk("lat_100_7", l, 9);
    chk("busy_cycles_100_7", nb, 9);
    chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2);
    chk("dbz_100_7", div_by_zero, 0);

    go(5, 0, l, nb);
    chk("lat_5_0", l, 1);
    chk("q_5_0", quotient, 8'hFF);
    chk("r_5_0", remainder, 5);
    chk("dbz_5_0", div_by_zero, 1);
    go(9, 3, l, nb);
    chk("q_9_3", quotient, 3);
    chk("r_9_3", remainder, 0);
    chk("dbz_9_3", div_by_zero, 0);

    go(3, 200, l, nb);
    chk("q_3_200", quotient, 0);
    chk("r_3_200", remainder, 3);
    go(255, 1, l, nb);
    chk("q_255_1", quotient, 255);
    chk("r_255_1", remainder, 0);
    go(255, 255, l, nb);
    chk("q_255_255", quotient, 1);
    chk("r_255_255", remainder, 0);

    // start pulses during CALC and DONE must be dropped
    @(negedge clk);
    dividend = 100;
    divisor = 7;
    start = 1'b1;
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      start = (i == 2 || i == 8);
      nd += int'(done);
      @(negedge clk);
    end
    chk("ignored_done_count", nd, 1);
    chk("ignored_q", quotient, 14);
    chk("ignored_r", remainder, 2);

    // start held high through DONE
    dividend = 20;
    divisor = 4;
    start = 1'b1;
    @(negedge clk);
    wait_done(l, nb);
    chk("hold_lat1", l, 9);
    chk("hold_q1", quotient, 5);
    chk("hold_r1", remainder, 0);
    dividend = 60;
    divisor = 7;
    @(negedge clk);
    chk("hold_idle_gap", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_accepted", busy, 1);
    wait_done(l, nb);
    chk("hold_lat2", l, 9);
    chk("hold_q2", quotient, 8);
    chk("hold_r2", remainder, 4);

    // reset mid-CALC
    @(negedge clk);
    dividend = 200;
    divisor = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("midrst_no_done", nd, 0);
    go(50, 6, l, nb);
    chk("q_50_6", quotient, 8);
    chk("r_50_6", remainder, 2);

`ifdef MYDIV_SIGNED_EN
    go(8'hF9, 2, l, nb);
    chk("q_m7_2", quotient, 8'hFD);
    chk("r_m7_2", remainder, 8'hFF);
    go(7, 8'hFE, l, nb);
    chk("q_7_m2", quotient, 8'hFD);
    chk("r_7_m2", remainder, 8'h01);
    go(8'h80, 8'hFF, l, nb);
    chk("q_m128_m1", quotient, 8'h80);
    chk("r_m128_m1", remainder, 0);
    chk("dbz_m128_m1", div_by_zero, 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
